fifo_sync_flags: RTL

Single-clock, parametrised FIFO buffer: the synchronous successor to the team's dual-clock FIFO, for blocks that live entirely in one clock domain (e.g. the I2C TX/RX data queues). On top of full/empty it adds parametrised almost-full/almost-empty thresholds, a live fill count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. Pointers and flags are derived from a single registered occupancy count, so there are no gray-code synchronisers.

---
 rtl/fifo_sync_flags.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, a live fill count and
// sticky overflow/underflow errors; optional first-word-fall-through read port.
module fifo_sync_flags #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_TH  = 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic                winc_i,
  input  logic                rinc_i,
  input  logic                clr_err_i,
  output logic [DATASIZE-1:0] rdata_o,
  output logic                wfull_o,
  output logic                rempty_o,
  output logic                w_almost_full_o,
  output logic                r_almost_empty_o,
  output logic [ADDRSIZE:0]   count_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0]   CNT_ONE    = (ADDRSIZE+1)'(1);
  localparam logic [ADDRSIZE:0]   FULL_LVL   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0]   AFULL_LVL  = (ADDRSIZE+1)'(DEPTH - AFULL_TH);
  localparam logic [ADDRSIZE:0]   AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_TH);
  localparam logic [ADDRSIZE-1:0] PTR_ONE    = ADDRSIZE'(1);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE-1:0] wptr, rptr;
  logic [ADDRSIZE:0]   count_q, count_nxt;
  logic                wr_en, rd_en;

  // Acceptance is judged on the registered flags, so a full FIFO can still take a
  // read while dropping the write, and an empty one the reverse.
  assign wr_en = winc_i & ~wfull_o;
  assign rd_en = rinc_i & ~rempty_o;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr             <= '0;
      rptr             <= '0;
      count_q          <= '0;
      wfull_o          <= 1'b0;
      rempty_o         <= 1'b1;
      w_almost_full_o  <= 1'b0;
      r_almost_empty_o <= 1'b1;
      overflow_o       <= 1'b0;
      underflow_o      <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
      count_q          <= count_nxt;
      wfull_o          <= (count_nxt == FULL_LVL);
      rempty_o         <= (count_nxt == '0);
      w_almost_full_o  <= (count_nxt >= AFULL_LVL);
      r_almost_empty_o <= (count_nxt <= AEMPTY_LVL);
      // A new error in the same cycle as clr_err_i wins over the clear.
      overflow_o       <= (winc_i & wfull_o)  | (overflow_o  & ~clr_err_i);
      underflow_o      <= (rinc_i & rempty_o) | (underflow_o & ~clr_err_i);
    end
  end

  assign count_o = count_q;

  // NOTE: the storage array has no reset; only pointers and count define its valid contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= wdata_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o = mem[rptr];
    end else begin : g_std
      logic [DATASIZE-1:0] rdata_q;
      always_ff @(posedge clk_i) begin
        if (rst_i)      rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rptr];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

endmodule
